// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data access sequencer onto the shared data bus
// Optional bus-wait abort enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter logic [31:0] DM_HI = 32'h0000_2FFF
`ifdef DMEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_flush,
  input  logic        cpu_load,
  input  logic        cpu_store,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [4:0]  cpu_exc,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [3:0]  bus_sel,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic        r_bus_valid;
  logic [3:0]  r_bus_sel;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_cpu_rdata;

  logic        w_is_dm;
  logic        w_is_t0;
  logic        w_is_t1;
  logic        w_is_ig;
  logic [3:0]  w_sel;
  logic        w_word;
  logic        w_half;
  logic        w_misalign;
  logic        w_timer_narrow;
  logic        w_count_store;
  logic        w_err;
  logic        w_access;
  logic [4:0]  w_exc_code;
  logic        w_timeout;

  // Address decode and access screening, purely from the MEM-stage inputs
  assign w_is_dm = (cpu_addr <= DM_HI);
  assign w_is_t0 = (cpu_addr >= 32'h0000_7F00) && (cpu_addr <= 32'h0000_7F0B);
  assign w_is_t1 = (cpu_addr >= 32'h0000_7F10) && (cpu_addr <= 32'h0000_7F1B);
  assign w_is_ig = (cpu_addr >= 32'h0000_7F20) && (cpu_addr <= 32'h0000_7F23);
  assign w_sel   = {w_is_ig, w_is_t1, w_is_t0, w_is_dm};

  assign w_word         = (cpu_size == 2'b10);
  assign w_half         = (cpu_size == 2'b01);
  assign w_misalign     = (w_word && (cpu_addr[1:0] != 2'b00)) || (w_half && cpu_addr[0]);
  assign w_timer_narrow = (w_is_t0 || w_is_t1) && !w_word;
  assign w_count_store  = cpu_store &&
                          ((cpu_addr == 32'h0000_7F08) || (cpu_addr == 32'h0000_7F18));

  assign w_err      = (cpu_load || cpu_store) &&
                      (w_misalign || w_timer_narrow || w_count_store || (w_sel == 4'b0000));
  assign w_access   = (cpu_load || cpu_store) && !cpu_flush && !w_err;
  assign w_exc_code = cpu_load ? EXC_ADEL : EXC_ADES;

`ifdef DMEM_TIMEOUT_EN
  logic [4:0] r_wait_cnt;
  logic       r_timeout;

  assign w_timeout = (r_state == S_BUSY) && !bus_ready &&
                     (r_wait_cnt == 5'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_access) w_next = S_BUSY;
      S_BUSY:  if (bus_ready || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stall is combinational in IDLE so the pipeline freezes in the request cycle
  always_comb begin
    cpu_stall = 1'b0;
    cpu_exc   = EXC_NONE;
    case (r_state)
      S_IDLE: begin
        cpu_stall = w_access;
        if (!cpu_flush && w_err) cpu_exc = w_exc_code;
      end
      S_BUSY: cpu_stall = 1'b1;
`ifdef DMEM_TIMEOUT_EN
      S_DONE: if (r_timeout) cpu_exc = r_bus_we ? EXC_ADES : EXC_ADEL;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_valid <= 1'b0;
      r_bus_sel   <= 4'b0000;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= 32'h0;
      r_cpu_rdata <= 32'h0;
`ifdef DMEM_TIMEOUT_EN
      r_wait_cnt  <= 5'd0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_bus_valid <= 1'b1;
            r_bus_sel   <= w_sel;
            r_bus_we    <= cpu_store;
            r_bus_addr  <= cpu_addr;
            r_bus_be    <= cpu_store ? cpu_be : 4'b0000;
            r_bus_wdata <= cpu_wdata;
`ifdef DMEM_TIMEOUT_EN
            r_wait_cnt  <= 5'd0;
`endif
          end
        end
        S_BUSY: begin
          if (bus_ready) begin
            r_cpu_rdata <= bus_rdata;
            r_bus_valid <= 1'b0;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (w_timeout) begin
            r_cpu_rdata <= 32'h0;
            r_bus_valid <= 1'b0;
            r_timeout   <= 1'b1;
          end else begin
            r_wait_cnt  <= r_wait_cnt + 5'd1;
          end
`endif
        end
`ifdef DMEM_TIMEOUT_EN
        S_DONE: r_timeout <= 1'b0;
`endif
        default: ;
      endcase
    end
  end

  assign bus_valid = r_bus_valid;
  assign bus_sel   = r_bus_sel;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;
  assign cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_flush, cpu_load, cpu_store;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [4:0]  cpu_exc;
  logic        bus_valid, bus_ready, bus_we;
  logic [3:0]  bus_sel, bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef struct {
    logic [3:0]  sel;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    string       name;
    logic        ld, st, fl;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          dly;
    logic [4:0]  exc;
    logic        acc;
    logic [3:0]  sel;
  } vec_t;

  txn_t sb_q[$];
  vec_t vecs[$];

  dmem_access_ctrl dut (
    .clk(clk), .reset(reset), .cpu_flush(cpu_flush), .cpu_load(cpu_load),
    .cpu_store(cpu_store), .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_exc(cpu_exc),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic ld, input logic st, input logic fl,
                              input logic [1:0] sz, input logic [31:0] addr, input logic [3:0] be,
                              input int dly, input logic [4:0] exc, input logic [3:0] sel);
    vec_t v;
    v.name = name; v.ld = ld; v.st = st; v.fl = fl; v.sz = sz; v.addr = addr;
    v.be = be; v.wd = {addr[15:0], 16'hC0DE}; v.dly = dly; v.exc = exc;
    v.sel = sel; v.acc = (sel != 4'b0000);
    return v;
  endfunction

  task automatic idle_inputs();
    cpu_load = 1'b0; cpu_store = 1'b0; cpu_flush = 1'b0;
  endtask

  task automatic drive(input logic ld, input logic st, input logic fl, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    cpu_load = ld; cpu_store = st; cpu_flush = fl; cpu_size = sz;
    cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
  endtask

  task automatic push_exp(input logic st, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
    txn_t t;
    t.sel = sel; t.we = st; t.addr = addr; t.be = st ? be : 4'b0000;
    t.wdata = wd; t.rdata = $urandom;
    sb_q.push_back(t);
  endtask

  // Entered at the negedge of the first BUSY cycle; returns at the negedge of DONE.
  task automatic run_txn(input int dly);
    txn_t e;
    int   stalls = 1;
    chk("sb depth", sb_q.size(), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    chk("bus_valid rise", {31'b0, bus_valid}, 1);
    chk("bus_sel", {28'b0, bus_sel}, {28'b0, e.sel});
    chk("bus_we", {31'b0, bus_we}, {31'b0, e.we});
    chk("bus_addr", bus_addr, e.addr);
    chk("bus_be", {28'b0, bus_be}, {28'b0, e.be});
    chk("bus_wdata", bus_wdata, e.wdata);
    for (int i = 0; i < dly; i++) begin
      if (cpu_stall) stalls++;
      @(negedge clk);
    end
    chk("hold valid", {31'b0, bus_valid}, 1);
    chk("hold addr", bus_addr, e.addr);
    chk("hold wdata", bus_wdata, e.wdata);
    if (cpu_stall) stalls++;
    bus_ready = 1'b1;
    bus_rdata = e.rdata;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    bus_rdata = $urandom;
    @(negedge clk);
    chk("done stall", {31'b0, cpu_stall}, 0);
    chk("done rdata", cpu_rdata, e.rdata);
    chk("done valid", {31'b0, bus_valid}, 0);
    chk("done exc", {27'b0, cpu_exc}, 0);
    chk("stall cycles", stalls, 2 + dly);
  endtask

  initial begin
    vecs.push_back(mk("lw_dm",     1, 0, 0, SZ_W, 32'h0000_1004, 4'hF,    0, 5'd0, 4'b0001));
    vecs.push_back(mk("sb_t1",     0, 1, 0, SZ_B, 32'h0000_7F11, 4'b0010, 0, 5'd5, 4'b0000));
    vecs.push_back(mk("lh_mis",    1, 0, 0, SZ_H, 32'h0000_0003, 4'hF,    0, 5'd4, 4'b0000));
    vecs.push_back(mk("sw_cnt0",   0, 1, 0, SZ_W, 32'h0000_7F08, 4'hF,    0, 5'd5, 4'b0000));
    vecs.push_back(mk("sw_t0",     0, 1, 0, SZ_W, 32'h0000_7F04, 4'hF,    1, 5'd0, 4'b0010));
    vecs.push_back(mk("lw_oor",    1, 0, 0, SZ_W, 32'h0000_3000, 4'hF,    0, 5'd4, 4'b0000));
    vecs.push_back(mk("lw_oor_fl", 1, 0, 1, SZ_W, 32'h0000_3000, 4'hF,    0, 5'd0, 4'b0000));
    vecs.push_back(mk("sw_dly",    0, 1, 0, SZ_W, 32'h0000_0020, 4'hF,    4, 5'd0, 4'b0001));
    vecs.push_back(mk("lw_cnt0",   1, 0, 0, SZ_W, 32'h0000_7F08, 4'hF,    2, 5'd0, 4'b0010));
    vecs.push_back(mk("lw_t1",     1, 0, 0, SZ_W, 32'h0000_7F18, 4'hF,    0, 5'd0, 4'b0100));
    vecs.push_back(mk("sw_cnt1",   0, 1, 0, SZ_W, 32'h0000_7F18, 4'hF,    0, 5'd5, 4'b0000));
    vecs.push_back(mk("sb_ig",     0, 1, 0, SZ_B, 32'h0000_7F23, 4'b1000, 1, 5'd0, 4'b1000));
    vecs.push_back(mk("sh_ig",     0, 1, 0, SZ_H, 32'h0000_7F22, 4'b1100, 0, 5'd0, 4'b1000));
    vecs.push_back(mk("lw_gap",    1, 0, 0, SZ_W, 32'h0000_7F24, 4'hF,    0, 5'd4, 4'b0000));
    vecs.push_back(mk("sw_gap",    0, 1, 0, SZ_W, 32'h0000_7F0C, 4'hF,    0, 5'd5, 4'b0000));
    vecs.push_back(mk("lh_t0",     1, 0, 0, SZ_H, 32'h0000_7F00, 4'hF,    0, 5'd4, 4'b0000));
    vecs.push_back(mk("lb_dmhi",   1, 0, 0, SZ_B, 32'h0000_2FFF, 4'hF,    0, 5'd0, 4'b0001));
    vecs.push_back(mk("lh_dmhi",   1, 0, 0, SZ_H, 32'h0000_2FFF, 4'hF,    0, 5'd4, 4'b0000));
    vecs.push_back(mk("lb_past",   1, 0, 0, SZ_B, 32'h0000_3000, 4'hF,    0, 5'd4, 4'b0000));
    vecs.push_back(mk("sw_dmtop",  0, 1, 0, SZ_W, 32'h0000_2FFC, 4'hF,    3, 5'd0, 4'b0001));
    vecs.push_back(mk("nop",       0, 0, 0, SZ_W, 32'h0000_7F11, 4'hF,    0, 5'd0, 4'b0000));
    vecs.push_back(mk("sw_fl",     0, 1, 1, SZ_W, 32'h0000_0100, 4'hF,    0, 5'd0, 4'b0000));
    vecs.push_back(mk("sw_t1mis",  0, 1, 0, SZ_W, 32'h0000_7F12, 4'hF,    0, 5'd5, 4'b0000));

    reset = 1'b1; bus_ready = 1'b0; bus_rdata = 32'h0;
    drive(0, 0, 0, SZ_W, 32'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst valid", {31'b0, bus_valid}, 0);
    chk("rst sel", {28'b0, bus_sel}, 0);
    chk("rst we", {31'b0, bus_we}, 0);
    chk("rst be", {28'b0, bus_be}, 0);
    chk("rst addr", bus_addr, 0);
    chk("rst wdata", bus_wdata, 0);
    chk("rst rdata", cpu_rdata, 0);
    chk("rst stall", {31'b0, cpu_stall}, 0);
    chk("rst exc", {27'b0, cpu_exc}, 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      vec_t v;
      v = vecs[k];
      drive(v.ld, v.st, v.fl, v.sz, v.addr, v.be, v.wd);
      #1;
      chk({v.name, " exc"}, {27'b0, cpu_exc}, {27'b0, v.exc});
      chk({v.name, " stall"}, {31'b0, cpu_stall}, {31'b0, v.acc});
      if (v.acc) push_exp(v.st, v.sel, v.addr, v.be, v.wd);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      if (v.acc) begin
        run_txn(v.dly);
        @(negedge clk);
      end else begin
        chk({v.name, " no bus"}, {31'b0, bus_valid}, 0);
        chk({v.name, " no stall"}, {31'b0, cpu_stall}, 0);
      end
    end

    // bus_ready while idle is ignored
    bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    chk("idle ready valid", {31'b0, bus_valid}, 0);
    chk("idle ready stall", {31'b0, cpu_stall}, 0);

    // Flush while BUSY does not cancel the transaction
    drive(1, 0, 0, SZ_W, 32'h0000_0040, 4'hF, 32'h0);
    push_exp(1'b0, 4'b0001, 32'h0000_0040, 4'hF, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    cpu_flush = 1'b1;
    @(negedge clk);
    run_txn(1);
    cpu_flush = 1'b0;
    @(negedge clk);

    // Pipeline holds a load through DONE; DONE must not re-accept it
    drive(1, 0, 0, SZ_W, 32'h0000_0100, 4'hF, 32'h0);
    push_exp(1'b0, 4'b0001, 32'h0000_0100, 4'hF, 32'h0);
    @(posedge clk);
    @(negedge clk);
    run_txn(0);
    drive(0, 1, 0, SZ_W, 32'h0000_0200, 4'hF, 32'hCAFE_F00D);
    #1;
    chk("done no accept", {31'b0, cpu_stall}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("idle accepts next", {31'b0, cpu_stall}, 1);
    push_exp(1'b1, 4'b0001, 32'h0000_0200, 4'hF, 32'hCAFE_F00D);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    run_txn(2);
    @(negedge clk);

    // Reset during BUSY abandons the request
    drive(0, 1, 0, SZ_W, 32'h0000_0020, 4'hF, 32'h5555_AAAA);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("pre-rst valid", {31'b0, bus_valid}, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid-rst valid", {31'b0, bus_valid}, 0);
    chk("mid-rst stall", {31'b0, cpu_stall}, 0);
    chk("mid-rst addr", bus_addr, 0);
    chk("mid-rst exc", {27'b0, cpu_exc}, 0);

`ifdef DMEM_TIMEOUT_EN
    begin
      int busy_cycles = 0;
      drive(1, 0, 0, SZ_W, 32'h0000_0044, 4'hF, 32'h0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      while (bus_valid && busy_cycles < 40) begin
        busy_cycles++;
        @(negedge clk);
      end
      chk("timeout busy cycles", busy_cycles, 16);
      chk("timeout exc", {27'b0, cpu_exc}, 4);
      chk("timeout rdata", cpu_rdata, 0);
      chk("timeout stall", {31'b0, cpu_stall}, 0);
      @(negedge clk);
      chk("timeout exc clears", {27'b0, cpu_exc}, 0);
    end
`endif

    chk("sb empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
